hyperbus_target: RTL

- Oversampled HyperBus responder that emulates a HyperRAM device backed by on-chip block RAM.
- It is the device end of the bus that the FPGA otherwise forwards to external HyperRAM, so the Pico host can be tested against FPGA-internal memory with no external chip.
- All bus inputs are sampled on the fast system clock. Bus outputs use separate data/enable pins; the top level builds the tristates.

---
 rtl/hyperbus_target_if.sv | 31 +++
 rtl/hyperbus_target.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperbus_target_if.sv
`default_nettype none
// ============================================================================
// Module   : hyperbus_target_if
// Purpose  : HyperBus pin bundle between a host and the emulated HyperRAM
//            target. Outputs use split data/enable pins; tristates are built
//            at the top level.
// Revision : 1.0 - initial release
// ============================================================================
interface hyperbus_target_if;
  logic       hb_ck;
  logic       hb_ncs;
  logic [7:0] hb_dq_i;
  logic [7:0] hb_dq_o;
  logic       hb_dq_oe;
  logic       hb_rwds_i;
  logic       hb_rwds_o;
  logic       hb_rwds_oe;

  // Host side: drives clock, select and write data
  modport master (
    output hb_ck, hb_ncs, hb_dq_i, hb_rwds_i,
    input  hb_dq_o, hb_dq_oe, hb_rwds_o, hb_rwds_oe
  );

  // Device side: the emulated HyperRAM
  modport slave (
    input  hb_ck, hb_ncs, hb_dq_i, hb_rwds_i,
    output hb_dq_o, hb_dq_oe, hb_rwds_o, hb_rwds_oe
  );
endinterface
`default_nettype wire

// File: rtl/hyperbus_target.sv
`default_nettype none
// ============================================================================
// Module   : hyperbus_target
// Purpose  : Oversampled HyperBus responder emulating a HyperRAM device on
//            block RAM. All bus inputs are sampled on the fast clock ck,
//            which must run at least 8x the hb_ck frequency.
// Revision : 1.0 - initial release
// ============================================================================
module hyperbus_target #(
  parameter int          ADDR_W   = 10,
  parameter int          LATENCY  = 6,        // hb_ck cycles, always doubled; must be >= 1
  parameter logic [15:0] ID_VALUE = 16'h0C81
) (
  input  wire logic        ck,
  input  wire logic        reset,
  hyperbus_target_if.slave hb,
  output logic             busy,
  output logic [15:0]      txn_count
);

  // Index of the last latency event; data starts on the event after it
  localparam int LAST_LAT = 5 + 4 * LATENCY;
  localparam int EV_W     = $clog2(LAST_LAT + 1);
  // Synchroniser reset: hb_ck low, ncs high (deselected), rwds/dq low
  localparam logic [10:0] SYNC_RST = 11'b0_1_0_00000000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CA   = 3'd1,
    S_LAT  = 3'd2,
    S_RD   = 3'd3,
    S_WR   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [10:0]         sync_meta_q, sync_meta_d;
  logic [10:0]         sync_q, sync_d;
  logic                ck_prev_q, ck_prev_d;
  logic [EV_W-1:0]     ev_cnt_q, ev_cnt_d;
  logic [39:0]         ca_q, ca_d;
  logic                is_read_q, is_read_d;
  logic                is_reg_q, is_reg_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                odd_q, odd_d;
  logic                word_done_q, word_done_d;
  logic [7:0]          wr_hi_q, wr_hi_d;
  logic                wr_mask_hi_q, wr_mask_hi_d;
  logic [7:0]          dq_o_q, dq_o_d;
  logic                dq_oe_q, dq_oe_d;
  logic                rwds_o_q, rwds_o_d;
  logic                rwds_oe_q, rwds_oe_d;
  logic                busy_q, busy_d;
  logic [15:0]         txn_count_q, txn_count_d;

  logic [15:0]         mem [0:(2**ADDR_W)-1];
  logic [15:0]         mem_rdata_q;
  logic                mem_we_hi, mem_we_lo;
  logic [15:0]         mem_wdata;

  // Synchronised views; all four inputs share one synchroniser so they stay aligned
  logic                ck_s, ncs_s, rwds_s;
  logic [7:0]          dq_s;
  logic                ev;
  logic [47:0]         ca_next;
  logic [31:0]         ca_word;
  logic [15:0]         rd_word;
  logic                unused_ca_bits;

  assign ck_s    = sync_q[10];
  assign ncs_s   = sync_q[9];
  assign rwds_s  = sync_q[8];
  assign dq_s    = sync_q[7:0];
  assign ev      = (ck_s != ck_prev_q) && !ncs_s;
  assign ca_next = {ca_q, dq_s};
  assign ca_word = {ca_next[44:16], ca_next[2:0]};
  assign rd_word = is_reg_q ? ID_VALUE : mem_rdata_q;
  // Burst type and reserved column bits play no part in addressing
  assign unused_ca_bits = ^{ca_next[45], ca_next[15:3], ca_word[31:ADDR_W]};

  assign hb.hb_dq_o    = dq_o_q;
  assign hb.hb_dq_oe   = dq_oe_q;
  assign hb.hb_rwds_o  = rwds_o_q;
  assign hb.hb_rwds_oe = rwds_oe_q;
  assign busy          = busy_q;
  assign txn_count     = txn_count_q;

  // Next-state and output logic for the transaction FSM
  always_comb begin
    state_d      = state_q;
    sync_meta_d  = {hb.hb_ck, hb.hb_ncs, hb.hb_rwds_i, hb.hb_dq_i};
    sync_d       = sync_meta_q;
    ck_prev_d    = ck_s;
    ev_cnt_d     = ev_cnt_q;
    ca_d         = ca_q;
    is_read_d    = is_read_q;
    is_reg_d     = is_reg_q;
    addr_d       = addr_q;
    odd_d        = odd_q;
    word_done_d  = word_done_q;
    wr_hi_d      = wr_hi_q;
    wr_mask_hi_d = wr_mask_hi_q;
    dq_o_d       = dq_o_q;
    dq_oe_d      = dq_oe_q;
    rwds_o_d     = rwds_o_q;
    rwds_oe_d    = rwds_oe_q;
    busy_d       = busy_q;
    txn_count_d  = txn_count_q;
    mem_we_hi    = 1'b0;
    mem_we_lo    = 1'b0;
    mem_wdata    = {wr_hi_q, dq_s};

    if (state_q == S_IDLE) begin
      if (!ncs_s) begin
        state_d     = S_CA;
        busy_d      = 1'b1;
        rwds_oe_d   = 1'b1;   // rwds high during CA: fixed 2x latency
        rwds_o_d    = 1'b1;
        ev_cnt_d    = '0;
        odd_d       = 1'b0;
        word_done_d = 1'b0;
      end
    end else if (ncs_s) begin
      // Deselect ends the transaction from any active state
      state_d   = S_IDLE;
      dq_oe_d   = 1'b0;
      rwds_oe_d = 1'b0;
      dq_o_d    = 8'h00;
      rwds_o_d  = 1'b0;
      busy_d    = 1'b0;
      if ((state_q == S_RD || state_q == S_WR) && word_done_q)
        txn_count_d = txn_count_q + 16'd1;
    end else if (ev) begin
      case (state_q)
        S_CA: begin
          ca_d     = ca_next[39:0];
          ev_cnt_d = ev_cnt_q + 1'b1;
          if (ev_cnt_q == EV_W'(5)) begin
            is_read_d = ca_next[47];
            is_reg_d  = ca_next[46];
            addr_d    = ca_word[ADDR_W-1:0];
            rwds_oe_d = 1'b0;
            rwds_o_d  = 1'b0;
            state_d   = S_LAT;
          end
        end
        S_LAT: begin
          ev_cnt_d = ev_cnt_q + 1'b1;
          if (ev_cnt_q == EV_W'(LAST_LAT)) begin
            odd_d   = 1'b0;
            state_d = is_read_q ? S_RD : S_WR;
          end
        end
        S_RD: begin
          dq_oe_d   = 1'b1;
          rwds_oe_d = 1'b1;
          if (!odd_q) begin
            dq_o_d   = rd_word[15:8];
            rwds_o_d = 1'b1;
            odd_d    = 1'b1;
          end else begin
            // Advancing the address here prefetches the next word well
            // before the following even event
            dq_o_d      = rd_word[7:0];
            rwds_o_d    = 1'b0;
            odd_d       = 1'b0;
            addr_d      = addr_q + 1'b1;
            word_done_d = 1'b1;
          end
        end
        S_WR: begin
          if (!odd_q) begin
            wr_hi_d      = dq_s;
            wr_mask_hi_d = rwds_s;
            odd_d        = 1'b1;
          end else begin
            // rwds=1 masks the byte; register space ignores writes
            mem_we_hi   = !wr_mask_hi_q && !is_reg_q;
            mem_we_lo   = !rwds_s && !is_reg_q;
            odd_d       = 1'b0;
            addr_d      = addr_q + 1'b1;
            word_done_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and control registers with synchronous reset
  always_ff @(posedge ck) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sync_meta_q  <= SYNC_RST;
      sync_q       <= SYNC_RST;
      ck_prev_q    <= 1'b0;
      ev_cnt_q     <= '0;
      ca_q         <= '0;
      is_read_q    <= 1'b0;
      is_reg_q     <= 1'b0;
      addr_q       <= '0;
      odd_q        <= 1'b0;
      word_done_q  <= 1'b0;
      wr_hi_q      <= 8'h00;
      wr_mask_hi_q <= 1'b0;
      dq_o_q       <= 8'h00;
      dq_oe_q      <= 1'b0;
      rwds_o_q     <= 1'b0;
      rwds_oe_q    <= 1'b0;
      busy_q       <= 1'b0;
      txn_count_q  <= 16'h0000;
    end else begin
      state_q      <= state_d;
      sync_meta_q  <= sync_meta_d;
      sync_q       <= sync_d;
      ck_prev_q    <= ck_prev_d;
      ev_cnt_q     <= ev_cnt_d;
      ca_q         <= ca_d;
      is_read_q    <= is_read_d;
      is_reg_q     <= is_reg_d;
      addr_q       <= addr_d;
      odd_q        <= odd_d;
      word_done_q  <= word_done_d;
      wr_hi_q      <= wr_hi_d;
      wr_mask_hi_q <= wr_mask_hi_d;
      dq_o_q       <= dq_o_d;
      dq_oe_q      <= dq_oe_d;
      rwds_o_q     <= rwds_o_d;
      rwds_oe_q    <= rwds_oe_d;
      busy_q       <= busy_d;
      txn_count_q  <= txn_count_d;
    end
  end

  // Block RAM: byte-lane writes, registered read of the current word; contents survive reset
  always_ff @(posedge ck) begin
    if (mem_we_hi && !reset) mem[addr_q][15:8] <= mem_wdata[15:8];
    if (mem_we_lo && !reset) mem[addr_q][7:0]  <= mem_wdata[7:0];
    mem_rdata_q <= mem[addr_q];
  end

endmodule
`default_nettype wire
